core_seq: RTL and testbench

//  Multi-cycle instruction sequencer for the NPC core. Drives fetch/execute/memory/writeback ordering

---
 rtl/core_seq_if.sv | 43 ++++
 rtl/core_seq.sv | 131 +++++++++++++
 tb/tb_core_seq.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/core_seq_if.sv
// Bus bundle between the NPC sequencer and its fetch port, decoder, ALU/branch unit and LSU.
// master = sequencer side, slave = surrounding core / memory side.
interface core_seq_if #(
  parameter int CNT_WIDTH = 64
);
  // fetch handshake
  logic                 inst_req_o;
  logic [31:0]          inst_addr_o;
  logic                 inst_ack_i;
  logic [31:0]          inst_data_i;
  // decoder / branch unit
  logic [31:0]          inst_o;
  logic                 we_cu_i;
  logic                 jump_branch_i;
  logic [31:0]          jump_target_i;
  logic [1:0]           mem_op_i;
  logic                 ebreak_i;
  // LSU handshake and register file
  logic                 lsu_req_o;
  logic                 lsu_ack_i;
  logic                 rf_we_o;
  // status
  logic [31:0]          pc_o;
  logic                 retire_o;
  logic [CNT_WIDTH-1:0] instret_o;
  logic                 halted_o;
  logic [2:0]           state_o;
  logic                 wdog_err_o;

  modport master (
    output inst_req_o, inst_addr_o, inst_o, lsu_req_o, rf_we_o,
           pc_o, retire_o, instret_o, halted_o, state_o, wdog_err_o,
    input  inst_ack_i, inst_data_i, we_cu_i, jump_branch_i, jump_target_i,
           mem_op_i, ebreak_i, lsu_ack_i
  );

  modport slave (
    input  inst_req_o, inst_addr_o, inst_o, lsu_req_o, rf_we_o,
           pc_o, retire_o, instret_o, halted_o, state_o, wdog_err_o,
    output inst_ack_i, inst_data_i, we_cu_i, jump_branch_i, jump_target_i,
           mem_op_i, ebreak_i, lsu_ack_i
  );
endinterface

// File: rtl/core_seq.sv
// Multi-cycle fetch/decode/exec/mem/writeback sequencer for the NPC core; owns PC and retire count.
// Optional handshake watchdog enabled by defining SEQ_WATCHDOG_EN.
module core_seq #(
  parameter logic [31:0] PC_RESET    = 32'h8000_0000,
  parameter int          CNT_WIDTH   = 64,
  parameter int          WDOG_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  core_seq_if.master    bus
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;

  logic [2:0]           state_reg, state_next;
  logic [31:0]          pc_reg, pc_next;
  logic [31:0]          inst_reg;
  logic [CNT_WIDTH-1:0] instret_reg;
  logic                 halted_reg;
  logic                 wdog_err_reg;
  logic                 retire;
  logic                 is_mem_op;
  logic                 timeout;
  logic [31:0]          jump_pc;

  // Low two target bits are masked by the AND so every target bit is consumed.
  assign jump_pc   = bus.jump_target_i & 32'hFFFF_FFFC;
  assign is_mem_op = (bus.mem_op_i == 2'b01) || (bus.mem_op_i == 2'b10);

  // Strobes are suppressed whenever rst is high so an aborted instruction never retires.
  assign retire = !rst && ((state_reg == WB) || (state_reg == DECODE && bus.ebreak_i));

`ifdef SEQ_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);

  logic [WW-1:0] wait_reg, wait_next;
  logic          waiting;

  assign waiting = (state_reg == FETCH && !bus.inst_ack_i) ||
                   (state_reg == MEM   && !bus.lsu_ack_i);
  assign timeout = waiting && (wait_reg == WW'(WDOG_CYCLES));

  always_comb begin
    wait_next = '0;
    if (waiting && !timeout) begin
      wait_next = wait_reg + WW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_reg     <= '0;
      wdog_err_reg <= 1'b0;
    end else begin
      wait_reg <= wait_next;
      if (timeout) begin
        wdog_err_reg <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;

  always_ff @(posedge clk) begin
    wdog_err_reg <= 1'b0;
  end
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:   if (bus.inst_ack_i) state_next = DECODE;
      DECODE:  state_next = bus.ebreak_i ? HALT : EXEC;
      EXEC:    state_next = is_mem_op ? MEM : WB;
      MEM:     if (bus.lsu_ack_i) state_next = WB;
      WB:      state_next = FETCH;
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
    if (timeout) begin
      state_next = HALT;
    end
  end

  always_comb begin
    pc_next = pc_reg;
    if (state_reg == WB) begin
      pc_next = bus.jump_branch_i ? jump_pc : pc_reg + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= FETCH;
      pc_reg      <= PC_RESET;
      inst_reg    <= '0;
      instret_reg <= '0;
      halted_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      if (state_reg == FETCH && bus.inst_ack_i) begin
        inst_reg <= bus.inst_data_i;
      end
      if (retire) begin
        instret_reg <= instret_reg + CNT_WIDTH'(1);
      end
      if (state_next == HALT) begin
        halted_reg <= 1'b1;
      end
    end
  end

  assign bus.inst_req_o  = !rst && (state_reg == FETCH);
  assign bus.lsu_req_o   = !rst && (state_reg == MEM);
  assign bus.rf_we_o     = !rst && (state_reg == WB) && bus.we_cu_i;
  assign bus.retire_o    = retire;
  assign bus.inst_addr_o = pc_reg;
  assign bus.pc_o        = pc_reg;
  assign bus.inst_o      = inst_reg;
  assign bus.instret_o   = instret_reg;
  assign bus.halted_o    = halted_reg;
  assign bus.state_o     = state_reg;
  assign bus.wdog_err_o  = wdog_err_reg;

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: instruction stream, stalled handshakes, jumps, wrap, reset abort, halt.
module tb_core_seq;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cnt_a;
  int   cnt_b;
  int   cyc;

  always #5 clk = ~clk;

  core_seq_if #(.CNT_WIDTH(64)) sif ();

  core_seq #(
    .PC_RESET   (32'h8000_0000),
    .CNT_WIDTH  (64),
    .WDOG_CYCLES(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst               = 1'b1;
    sif.inst_ack_i    = 1'b0;
    sif.inst_data_i   = 32'h0;
    sif.we_cu_i       = 1'b0;
    sif.jump_branch_i = 1'b0;
    sif.jump_target_i = 32'h0;
    sif.mem_op_i      = 2'b00;
    sif.ebreak_i      = 1'b0;
    sif.lsu_ack_i     = 1'b0;
    tick();
    tick();

    chk("rst_state",    64'(sif.state_o), 64'd0);
    chk("rst_pc",       64'(sif.pc_o), 64'h8000_0000);
    chk("rst_inst",     64'(sif.inst_o), 64'd0);
    chk("rst_instret",  sif.instret_o, 64'd0);
    chk("rst_halted",   64'(sif.halted_o), 64'd0);
    chk("rst_wdog",     64'(sif.wdog_err_o), 64'd0);
    chk("rst_inst_req", 64'(sif.inst_req_o), 64'd0);
    chk("rst_lsu_req",  64'(sif.lsu_req_o), 64'd0);
    chk("rst_rf_we",    64'(sif.rf_we_o), 64'd0);
    chk("rst_retire",   64'(sif.retire_o), 64'd0);

    // addi stream with zero-wait fetch
    rst             = 1'b0;
    sif.inst_ack_i  = 1'b1;
    sif.inst_data_i = 32'h0010_0093;
    sif.we_cu_i     = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      $display("step addi %0d pc=%h", i, sif.pc_o);
      chk("addi_fetch_addr", 64'(sif.inst_addr_o), 64'(32'h8000_0000 + 32'(4 * i)));
      chk("addi_fetch_req",  64'(sif.inst_req_o), 64'd1);
      chk("addi_fetch_ret",  64'(sif.retire_o), 64'd0);
      tick();
      chk("addi_decode", 64'(sif.state_o), 64'd1);
      chk("addi_ir",     64'(sif.inst_o), 64'h0010_0093);
      tick();
      chk("addi_exec",   64'(sif.state_o), 64'd2);
      tick();
      chk("addi_wb",     64'(sif.state_o), 64'd4);
      chk("addi_rf_we",  64'(sif.rf_we_o), 64'd1);
      chk("addi_retire", 64'(sif.retire_o), 64'd1);
      tick();
    end
    chk("addi_pc_end",      64'(sif.pc_o), 64'h8000_000C);
    chk("addi_instret_end", sif.instret_o, 64'd3);

    // fetch ack delayed by 3 cycles
    $display("step fetch_stall");
    sif.inst_ack_i  = 1'b0;
    sif.inst_data_i = 32'h0020_0113;
    #1;
    cnt_a = 0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_state", 64'(sif.state_o), 64'd0);
      chk("stall_addr",  64'(sif.inst_addr_o), 64'h8000_000C);
      cnt_a += int'(sif.inst_req_o);
      tick();
    end
    sif.inst_ack_i = 1'b1;
    #1;
    cnt_a += int'(sif.inst_req_o);
    tick();
    chk("stall_req_cycles", 64'(cnt_a), 64'd4);
    chk("stall_decode",     64'(sif.state_o), 64'd1);
    chk("stall_ir",         64'(sif.inst_o), 64'h0020_0113);
    sif.lsu_ack_i = 1'b1;  // spurious LSU ack on a non-memory instruction
    tick();
    tick();
    chk("spurious_lsu_wb", 64'(sif.state_o), 64'd4);
    tick();
    chk("stall_pc",      64'(sif.pc_o), 64'h8000_0010);
    chk("stall_instret", sif.instret_o, 64'd4);

    // load with LSU ack after 2 wait cycles
    $display("step load");
    sif.mem_op_i  = 2'b01;
    sif.lsu_ack_i = 1'b0;
    cyc = 0;
    #1;
    tick(); cyc++;
    tick(); cyc++;
    tick(); cyc++;
    chk("load_mem", 64'(sif.state_o), 64'd3);
    cnt_b = 0;
    for (int k = 0; k < 2; k++) begin
      cnt_b += int'(sif.lsu_req_o);
      tick(); cyc++;
    end
    sif.lsu_ack_i = 1'b1;
    #1;
    cnt_b += int'(sif.lsu_req_o);
    tick(); cyc++;
    chk("load_lsu_cycles", 64'(cnt_b), 64'd3);
    chk("load_wb",         64'(sif.state_o), 64'd4);
    chk("load_retire",     64'(sif.retire_o), 64'd1);
    tick(); cyc++;
    chk("load_total_cycles", 64'(cyc), 64'd7);
    chk("load_instret",      sif.instret_o, 64'd5);

    // store, zero-wait LSU, no register write
    $display("step store");
    sif.mem_op_i = 2'b10;
    sif.we_cu_i  = 1'b0;
    tick(); tick(); tick();
    chk("store_mem",    64'(sif.state_o), 64'd3);
    chk("store_lsureq", 64'(sif.lsu_req_o), 64'd1);
    tick();
    chk("store_wb",     64'(sif.state_o), 64'd4);
    chk("store_rf_we",  64'(sif.rf_we_o), 64'd0);
    chk("store_retire", 64'(sif.retire_o), 64'd1);
    tick();
    chk("store_pc",     64'(sif.pc_o), 64'h8000_0018);

    // mem_op 11 is treated as no memory access
    $display("step memop3");
    sif.mem_op_i = 2'b11;
    sif.we_cu_i  = 1'b1;
    tick(); tick(); tick();
    chk("memop3_wb", 64'(sif.state_o), 64'd4);
    tick();

    // jump with misaligned target, then wrap at the top of the address space
    $display("step jump");
    sif.mem_op_i      = 2'b00;
    sif.jump_branch_i = 1'b1;
    sif.jump_target_i = 32'h8000_0103;
    tick(); tick(); tick(); tick();
    chk("jump_addr",  64'(sif.inst_addr_o), 64'h8000_0100);
    chk("jump_state", 64'(sif.state_o), 64'd0);
    sif.jump_target_i = 32'hFFFF_FFFF;
    tick(); tick(); tick(); tick();
    chk("jump_top", 64'(sif.pc_o), 64'hFFFF_FFFC);
    sif.jump_branch_i = 1'b0;
    tick(); tick(); tick(); tick();
    chk("pc_wrap",      64'(sif.pc_o), 64'h0);
    chk("wrap_instret", sif.instret_o, 64'd10);

    // reset asserted during WB aborts the instruction
    $display("step reset_abort");
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("abort_rf_we",  64'(sif.rf_we_o), 64'd0);
    chk("abort_retire", 64'(sif.retire_o), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_state",   64'(sif.state_o), 64'd0);
    chk("abort_pc",      64'(sif.pc_o), 64'h8000_0000);
    chk("abort_instret", sif.instret_o, 64'd0);

    // ebreak halts; mem_op ignored
    $display("step ebreak");
    sif.ebreak_i = 1'b1;
    sif.mem_op_i = 2'b01;
    tick();
    chk("ebreak_retire", 64'(sif.retire_o), 64'd1);
    chk("ebreak_rf_we",  64'(sif.rf_we_o), 64'd0);
    tick();
    chk("halt_state",   64'(sif.state_o), 64'd5);
    chk("halt_flag",    64'(sif.halted_o), 64'd1);
    chk("halt_instret", sif.instret_o, 64'd1);
    sif.ebreak_i = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    for (int k = 0; k < 5; k++) begin
      cnt_a += int'(sif.retire_o);
      cnt_b += int'(sif.inst_req_o) + int'(sif.lsu_req_o);
      tick();
    end
    chk("halt_no_retire", 64'(cnt_a), 64'd0);
    chk("halt_no_req",    64'(cnt_b), 64'd0);
    chk("halt_stay",      64'(sif.state_o), 64'd5);
    chk("halt_pc",        64'(sif.pc_o), 64'h8000_0000);
    chk("halt_frozen",    sif.instret_o, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("unhalt_state", 64'(sif.state_o), 64'd0);
    chk("unhalt_flag",  64'(sif.halted_o), 64'd0);
    chk("unhalt_pc",    64'(sif.pc_o), 64'h8000_0000);

    // fetch ack never arrives
    $display("step no_ack");
    sif.inst_ack_i = 1'b0;
    sif.mem_op_i   = 2'b00;
    #1;
`ifdef SEQ_WATCHDOG_EN
    cyc = 0;
    while (sif.state_o != 3'd5 && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("wdog_halt",    64'(sif.state_o), 64'd5);
    chk("wdog_err",     64'(sif.wdog_err_o), 64'd1);
    chk("wdog_halted",  64'(sif.halted_o), 64'd1);
    chk("wdog_instret", sif.instret_o, 64'd0);
`else
    for (int k = 0; k < 20; k++) tick();
    chk("noack_state", 64'(sif.state_o), 64'd0);
    chk("noack_req",   64'(sif.inst_req_o), 64'd1);
    chk("noack_wdog",  64'(sif.wdog_err_o), 64'd0);
    chk("noack_addr",  64'(sif.inst_addr_o), 64'h8000_0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
